// File: rtl/dpram_be_clr.sv
// -----------------------------------------------------------------------------
// dpram_be_clr
//
// Data memory for the multi-cycle / FSM CPU labs. One write port (A) with
// per-byte lane enables and one combinational read port (B), both in the clk
// domain. A hardware clear sweep zeroes every entry after reset or when a
// clear is requested. While the sweep runs, busy is high and the core is
// expected to stall.
//
// Read-during-write to the same address is bypassed lane by lane. The read
// port therefore shows the word as it will look after this cycle's write.
//
// Optional feature (macro PARITY_EN):
//   Each entry also stores one even-parity bit per byte lane. pinj inverts the
//   stored parity of the lanes being written, so the error path can be
//   exercised. perr flags a parity failure on any non-bypassed lane of the
//   word being read. Without the macro, perr is tied to 0 and pinj is unused.
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width; DEPTH = 2**ADDR_W entries
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset; starts a clear sweep
//   clr    one-cycle clear request (ignored while busy)
//   wea    port A write enable
//   bea    port A byte-lane enables (bit i -> dina[8i+7:8i])
//   addra  port A address
//   dina   port A write data
//   addrb  port B read address
//   doutb  port B read data (combinational, 0 while busy)
//   busy   clear sweep in progress
//   pinj   parity inject (PARITY_EN only)
//   perr   parity error on the current read (PARITY_EN only, else 0)
// -----------------------------------------------------------------------------
module dpram_be_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wea,
    input  logic [DATA_W/8-1:0]   bea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    input  logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     doutb,
    output logic                  busy,
    input  logic                  pinj,
    output logic                  perr
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   caddr_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                idle;
    logic                clr_wr;
    logic                user_we;
    logic                addr_match;
    logic [DATA_W-1:0]   rd_word;

    // ------------------------------------------------------------------------
    // Control FSM: the sweep visits caddr 0..DEPTH-1 once, so it lasts exactly
    // DEPTH cycles. A reset always restarts the sweep from address 0, even
    // if a sweep is already running.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            caddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        caddr_q <= '0;
                    end
                end
                CLEAR: begin
                    caddr_q <= caddr_q + 1'b1;
                    if (caddr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    caddr_q <= '0;
                end
            endcase
        end
    end

    assign idle = (state_q == IDLE);
    assign busy = (state_q == CLEAR);

    // During a reset cycle, no write happens. The sweep restarts on the
    // following cycle. In IDLE, a clear request takes priority over a user
    // write issued in the same cycle.
    assign clr_wr  = busy && !rst;
    assign user_we = idle && !rst && !clr && wea;

    // ------------------------------------------------------------------------
    // Storage. bea = 0 naturally falls out as a no-op.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[caddr_q] <= '0;
        end else if (user_we) begin
            for (int i = 0; i < NB; i++) begin
                if (bea[i]) begin
                    mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
                end
            end
        end
    end

    assign rd_word    = mem[addrb];
    assign addr_match = (addra == addrb);

`ifdef PARITY_EN
    // One even-parity bit per lane. A stored 0 is correct for an all-zero
    // byte, so the sweep can clear both arrays the same way.
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_par;
    logic [NB-1:0] lane_perr;

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            par_mem[caddr_q] <= '0;
        end else if (user_we) begin
            for (int i = 0; i < NB; i++) begin
                if (bea[i]) begin
                    par_mem[addra][i] <= (^dina[i*8 +: 8]) ^ pinj;
                end
            end
        end
    end

    assign rd_par = par_mem[addrb];
    assign perr   = idle && (|lane_perr);
`else
    logic unused_pinj;
    assign unused_pinj = pinj;
    assign perr        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Read path, one lane at a time. A lane is bypassed only when this cycle's
    // write really commits to that lane. Otherwise it shows the stored lane.
    // The whole word reads 0 while the sweep is running.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic       lane_byp;
            logic [7:0] lane_val;

            assign lane_byp = user_we && bea[gi] && addr_match;
            assign lane_val = lane_byp ? dina[gi*8 +: 8] : rd_word[gi*8 +: 8];
            assign doutb[gi*8 +: 8] = idle ? lane_val : 8'h00;
`ifdef PARITY_EN
            // Bypassed lanes come straight from dina and are never checked.
            assign lane_perr[gi] = !lane_byp && ((^rd_word[gi*8 +: 8]) != rd_par[gi]);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dpram_be_clr.sv
// -----------------------------------------------------------------------------
// tb_dpram_be_clr
//
// Directed steps followed by a randomized phase for dpram_be_clr at its default
// size (32-bit words, 128 entries). The reference model keeps the memory as a
// plain array. It tracks the clear sweep as "cycles left / next address to
// zero" and predicts doutb, busy and perr before every rising edge.
// -----------------------------------------------------------------------------
module tb_dpram_be_clr;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int NB     = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, clr, wea, pinj;
    logic [NB-1:0]     bea;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] doutb;
    logic              busy, perr;

    dpram_be_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .wea   (wea),
        .bea   (bea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb),
        .busy  (busy),
        .pinj  (pinj),
        .perr  (perr)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [NB-1:0]     m_par [DEPTH];
    int                m_left = 0;   // sweep cycles still to run
    int                m_pos  = 0;   // next entry the sweep zeroes

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic write_commits();
        return (m_left == 0) && !rst && !clr && wea;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic w, input logic [NB-1:0] be,
                         input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] ab, input logic pj);
        rst = r; clr = c; wea = w; bea = be; addra = aa; dina = d; addrb = ab; pinj = pj;
    endtask

    task automatic drive_idle(input logic [ADDR_W-1:0] ab);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, ab, 1'b0);
    endtask

    // Predict the combinational outputs for the inputs now applied, then compare.
    task automatic check_outputs(input string tag);
        logic [DATA_W-1:0] exp_dout;
        logic              exp_perr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] byp;
        #1;
        exp_dout = '0;
        exp_perr = 1'b0;
        if (m_left == 0) begin
            stored = m_mem[addrb];
            byp    = (write_commits() && addra == addrb) ? lane_mask(bea) : '0;
            exp_dout = (stored & ~byp) | (dina & byp);
            for (int i = 0; i < NB; i++) begin
                if (!byp[i*8] && ((^stored[i*8 +: 8]) != m_par[addrb][i])) exp_perr = 1'b1;
            end
        end
`ifndef PARITY_EN
        exp_perr = 1'b0;
`endif
        chk({tag, "/busy"}, {31'd0, busy}, {31'd0, m_left > 0});
        chk({tag, "/doutb"}, doutb, exp_dout);
        chk({tag, "/perr"}, {31'd0, perr}, {31'd0, exp_perr});
    endtask

    // Commit the applied inputs into the model and advance one clock.
    task automatic tick();
        logic [DATA_W-1:0] mk;
        if (rst || clr || wea)
            $display("txn t=%0t rst=%0b clr=%0b wea=%0b bea=%h addra=%0d dina=%h pinj=%0b addrb=%0d doutb=%h busy=%0b perr=%0b",
                     $time, rst, clr, wea, bea, addra, dina, pinj, addrb, doutb, busy, perr);
        if (rst) begin
            m_left = DEPTH;
            m_pos  = 0;
        end else if (m_left > 0) begin
            m_mem[m_pos] = '0;
            m_par[m_pos] = '0;
            m_pos++;
            m_left--;
        end else if (clr) begin
            m_left = DEPTH;
            m_pos  = 0;
        end else if (wea) begin
            mk = lane_mask(bea);
            m_mem[addra] = (m_mem[addra] & ~mk) | (dina & mk);
            for (int i = 0; i < NB; i++) begin
                if (bea[i]) m_par[addra][i] = (^dina[i*8 +: 8]) ^ pinj;
            end
        end
        @(negedge clk);
    endtask

    // Idle until busy drops (bounded), checking every cycle. Returns the cycle count.
    task automatic run_sweep(output int n);
        n = 0;
        drive_idle('0);
        while (busy === 1'b1 && n < 300) begin
            check_outputs("sweep");
            tick();
            n++;
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        drive(1'b0, 1'b0, 1'b1, be, a, d, a ^ 7'h40, 1'b0);
        check_outputs("wr");
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        drive_idle(a);
        check_outputs(tag);
        chk(tag, doutb, d);
        tick();
    endtask

    initial begin
        int n;
        int k;
        logic [DATA_W-1:0] w4;

        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_par[i] = '0;
        end

        // Reset: one cycle, then the sweep must last exactly DEPTH cycles.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        drive_idle(7'd5);
        check_outputs("after_rst");
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_dout", doutb, 32'd0);
        run_sweep(n);
        chk("rst_sweep_len", n, DEPTH);

        for (int a = 0; a < DEPTH; a++) begin
            drive_idle(a[ADDR_W-1:0]);
            check_outputs("scan0");
            tick();
        end

        // Clear request timing.
        write_word(7'd5, 32'hDEADBEEF, 4'hF);
        read_expect("rd5", 7'd5, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, 7'd5, 1'b0);
        check_outputs("clr_cycle");
        chk("clr_busy_same", {31'd0, busy}, 32'd0);
        tick();
        drive_idle(7'd5);
        chk("clr_busy_next", {31'd0, busy}, 32'd1);
        run_sweep(n);
        chk("clr_sweep_len", n, DEPTH);
        read_expect("rd5_clr", 7'd5, 32'd0);

        // Byte enables.
        write_word(7'd9, 32'h11223344, 4'b1111);
        write_word(7'd9, 32'hAABBCCDD, 4'b0101);
        read_expect("be_merge", 7'd9, 32'h11BB33DD);
        write_word(7'd9, 32'h99999999, 4'b0000);
        read_expect("be_zero", 7'd9, 32'h11BB33DD);

        // Bypass.
        w4 = $urandom;
        write_word(7'd3, 32'h01020304, 4'hF);
        write_word(7'd4, w4, 4'hF);
        drive(1'b0, 1'b0, 1'b1, 4'b0011, 7'd3, 32'hFFFFAAAA, 7'd3, 1'b0);
        check_outputs("byp_same");
        chk("byp_same", doutb, 32'h0102AAAA);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'b0011, 7'd3, 32'hFFFFAAAA, 7'd4, 1'b0);
        check_outputs("byp_other");
        chk("byp_other", doutb, w4);
        tick();

        // Busy interlocks: mid-sweep write and clr are ignored.
        write_word(7'd7, 32'hCAFEF00D, 4'hF);
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        check_outputs("clr2");
        tick();
        drive_idle(7'd7);
        k = 0;
        repeat (20) begin
            check_outputs("sweep");
            tick();
            k++;
        end
        drive(1'b0, 1'b1, 1'b1, 4'hF, 7'd7, 32'h00000055, 7'd7, 1'b0);
        check_outputs("busy_wr");
        chk("busy_dout", doutb, 32'd0);
        tick();
        k++;
        run_sweep(n);
        chk("busy_no_restart", k + n, DEPTH);
        read_expect("busy_no_write", 7'd7, 32'd0);

        // clr and wea in the same idle cycle: clr wins.
        write_word(7'd10, 32'h0BADCAFE, 4'hF);
        drive(1'b0, 1'b1, 1'b1, 4'hF, 7'd10, 32'h12345678, 7'd10, 1'b0);
        check_outputs("clr_wea");
        tick();
        run_sweep(n);
        chk("clr_wea_len", n, DEPTH);
        read_expect("clr_wea_rd", 7'd10, 32'd0);

        // Reset at sweep cycle 60 restarts the full sweep.
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        drive_idle('0);
        repeat (59) begin
            check_outputs("sweep");
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        check_outputs("mid_rst");
        tick();
        run_sweep(n);
        chk("mid_rst_len", n, DEPTH);

        // Address boundaries.
        write_word(7'd127, 32'hA5A5_0127, 4'hF);
        write_word(7'd0, 32'h5A5A_0000, 4'hF);
        read_expect("top", 7'd127, 32'hA5A5_0127);
        read_expect("bottom", 7'd0, 32'h5A5A_0000);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                  $urandom_range(0, 1), NB'($urandom), ADDR_W'($urandom_range(0, 15)),
                  $urandom, ADDR_W'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            check_outputs("rand");
            tick();
        end
        run_sweep(n);

`ifdef PARITY_EN
        drive(1'b0, 1'b0, 1'b1, 4'b0001, 7'd2, 32'h000000FF, 7'd3, 1'b1);
        check_outputs("pinj_wr");
        tick();
        drive_idle(7'd2);
        check_outputs("pinj_rd");
        chk("perr_inj", {31'd0, perr}, 32'd1);
        tick();
        write_word(7'd2, 32'h000000FF, 4'b0001);
        drive_idle(7'd2);
        check_outputs("pinj_fix");
        chk("perr_fixed", {31'd0, perr}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'b0001, 7'd2, 32'h000000FF, 7'd3, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        run_sweep(n);
        for (int a = 0; a < DEPTH; a++) begin
            drive_idle(a[ADDR_W-1:0]);
            check_outputs("perr_scan");
            tick();
        end
`else
        drive(1'b0, 1'b0, 1'b1, 4'b0001, 7'd2, 32'h000000FF, 7'd3, 1'b1);
        tick();
        drive_idle(7'd2);
        check_outputs("noparity");
        chk("perr_tied", {31'd0, perr}, 32'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
